// File: rtl/switch_event_detector.sv
// Synchroniser, debouncer and press/release/long-press event generator for one raw switch.
// Optional macro SWITCH_EVENT_REPEAT_EN: long-press auto-repeats every LONG_PRESS_LIMIT cycles.
module switch_event_detector #(
  parameter int DEBOUNCE_LIMIT   = 5000000,
  parameter int LONG_PRESS_LIMIT = 25000000,
  parameter int COUNT_WIDTH      = 8
) (
  input  logic                   i_clock,
  input  logic                   i_rst_n,
  input  logic                   i_switch,
  output logic                   o_filtered_switch,
  output logic                   o_press,
  output logic                   o_release,
  output logic                   o_long_press,
  output logic [COUNT_WIDTH-1:0] o_press_count
);

  localparam int DEB_W  = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_LIMIT + 1);

  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_LIMIT);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_LIMIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
`ifndef SWITCH_EVENT_REPEAT_EN
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_LIMIT);
`endif

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   sync_s1;
  logic                   sync_s;
  logic [DEB_W-1:0]       deb_cnt;
  logic [DEB_W-1:0]       deb_cnt_next;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [HOLD_W-1:0]      hold_cnt_next;
  logic                   level;
  logic                   accept_press;
  logic                   accept_release;
  logic                   long_hit;
  logic                   press_q;
  logic                   release_q;
  logic                   long_q;
  logic [COUNT_WIDTH-1:0] press_count_q;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_s1 <= 1'b0;
      sync_s  <= 1'b0;
    end else begin
      sync_s1 <= i_switch;
      sync_s  <= sync_s1;
    end
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      deb_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      deb_cnt  <= deb_cnt_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  assign level = (state == PRESSED) || (state == DEB_RELEASE);

  // A level change is accepted only once the counter has already reached the limit
  // while the synchronised input still disagrees; any agreeing cycle restarts it.
  always_comb begin
    state_next     = state;
    deb_cnt_next   = '0;
    accept_press   = 1'b0;
    accept_release = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync_s) begin
          state_next   = DEB_PRESS;
          deb_cnt_next = DEB_ONE;
        end
      end
      DEB_PRESS: begin
        if (!sync_s) begin
          state_next = IDLE;
        end else if (deb_cnt == DEB_MAX) begin
          state_next   = PRESSED;
          accept_press = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt + DEB_ONE;
        end
      end
      PRESSED: begin
        if (!sync_s) begin
          state_next   = DEB_RELEASE;
          deb_cnt_next = DEB_ONE;
        end
      end
      DEB_RELEASE: begin
        if (sync_s) begin
          state_next = PRESSED;
        end else if (deb_cnt == DEB_MAX) begin
          state_next     = IDLE;
          accept_release = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt + DEB_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Hold counter reads 0 in the press cycle, so reaching LIMIT-1 while still held
  // means the long-press pulse lands exactly LIMIT cycles after o_press.
  assign long_hit = level && (hold_cnt == HOLD_LAST);

  always_comb begin
    hold_cnt_next = hold_cnt;
    if (accept_press) begin
      hold_cnt_next = '0;
    end else if (level) begin
`ifdef SWITCH_EVENT_REPEAT_EN
      hold_cnt_next = long_hit ? '0 : hold_cnt + HOLD_ONE;
`else
      hold_cnt_next = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HOLD_ONE;
`endif
    end
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      long_q        <= 1'b0;
      press_count_q <= '0;
    end else begin
      press_q   <= accept_press;
      release_q <= accept_release;
      long_q    <= long_hit;
      if (accept_press) begin
        press_count_q <= press_count_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign o_filtered_switch = level;
  assign o_press           = press_q;
  assign o_release         = release_q;
  assign o_long_press      = long_q;
  assign o_press_count     = press_count_q;

endmodule

// File: tb/tb_switch_event_detector.sv
// Randomised scoreboard bench for switch_event_detector (DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=10).
// Reference model: a raw-sample sliding window decides acceptance; long presses come from edge arithmetic.
module tb_switch_event_detector;

  localparam int DL  = 4;
  localparam int LPL = 10;
  localparam int CW  = 8;

  logic          i_clock = 1'b0;
  logic          i_rst_n;
  logic          i_switch;
  logic          o_filtered_switch;
  logic          o_press;
  logic          o_release;
  logic          o_long_press;
  logic [CW-1:0] o_press_count;

  switch_event_detector #(
    .DEBOUNCE_LIMIT  (DL),
    .LONG_PRESS_LIMIT(LPL),
    .COUNT_WIDTH     (CW)
  ) dut (
    .i_clock          (i_clock),
    .i_rst_n          (i_rst_n),
    .i_switch         (i_switch),
    .o_filtered_switch(o_filtered_switch),
    .o_press          (o_press),
    .o_release        (o_release),
    .o_long_press     (o_long_press),
    .o_press_count    (o_press_count)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    int edge_no;
    bit press;
    bit rel;
    bit lp;
    bit level;
    int count;
  } exp_t;

  exp_t sb_q[$];
  bit   hist[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_idx = 0;
  bit   m_level;
  int   m_count;
  int   m_press_edge;
  int   long_seen = 0;
  int   rel_seen = 0;

  bit   mdl_toggle;
  bit   mdl_lp;
  int   mdl_age;
  exp_t mdl_item;
  exp_t mon_item;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (edge %0d)", name, actual, expected, edge_idx);
    end
  endtask

  task automatic model_reset();
    m_level      = 1'b0;
    m_count      = 0;
    m_press_edge = 0;
    hist.delete();
    for (int i = 0; i < DL + 3; i++) hist.push_back(1'b0);
    sb_q.delete();
  endtask

  // Reference: the level flips at edge e when the raw samples taken at edges e-2-DL..e-2
  // all differ from the current level (two sync stages plus DL+1 disagreeing cycles).
  always @(posedge i_clock) begin
    edge_idx++;
    if (!i_rst_n) begin
      model_reset();
    end else begin
      hist.push_back(i_switch);
      void'(hist.pop_front());
      mdl_toggle = 1'b1;
      for (int i = 0; i <= DL; i++) begin
        if (hist[i] == m_level) mdl_toggle = 1'b0;
      end
      mdl_age = edge_idx - m_press_edge;
`ifdef SWITCH_EVENT_REPEAT_EN
      mdl_lp = m_level && (mdl_age > 0) && ((mdl_age % LPL) == 0);
`else
      mdl_lp = m_level && (mdl_age == LPL);
`endif
      if (mdl_toggle) begin
        m_level = !m_level;
        if (m_level) begin
          m_count      = (m_count + 1) % (1 << CW);
          m_press_edge = edge_idx;
        end
      end
      if (mdl_toggle || mdl_lp) begin
        mdl_item.edge_no = edge_idx;
        mdl_item.press   = mdl_toggle && m_level;
        mdl_item.rel     = mdl_toggle && !m_level;
        mdl_item.lp      = mdl_lp;
        mdl_item.level   = m_level;
        mdl_item.count   = m_count;
        sb_q.push_back(mdl_item);
      end
    end
  end

  // Monitor: pops one expected event whenever the DUT pulses or an expected event is due.
  always @(negedge i_clock) begin
    check_output("level", o_filtered_switch, m_level);
    if (o_press || o_release || o_long_press ||
        (sb_q.size() > 0 && sb_q[0].edge_no <= edge_idx)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse press=%0b release=%0b long=%0b required none (edge %0d)",
                 o_press, o_release, o_long_press, edge_idx);
      end else begin
        mon_item = sb_q.pop_front();
        check_output("event_edge", edge_idx, mon_item.edge_no);
        check_output("press", o_press, mon_item.press);
        check_output("release", o_release, mon_item.rel);
        check_output("long_press", o_long_press, mon_item.lp);
        check_output("event_level", o_filtered_switch, mon_item.level);
        check_output("press_count", o_press_count, mon_item.count);
      end
    end
    if (i_rst_n) begin
      if (o_long_press) long_seen++;
      if (o_release) rel_seen++;
    end
  end

  task automatic apply_stimulus(input bit value, input int cycles);
    i_switch = value;
    repeat (cycles) @(negedge i_clock);
  endtask

  task automatic wait_press(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge i_clock);
      #1;
      if (o_press) begin
        n = i;
        found = 1'b1;
        break;
      end
    end
    if (!found) check_output("press_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_level"}, o_filtered_switch, 0);
    check_output({tag, "_press"}, o_press, 0);
    check_output({tag, "_release"}, o_release, 0);
    check_output({tag, "_long"}, o_long_press, 0);
    check_output({tag, "_count"}, o_press_count, 0);
  endtask

  task automatic do_reset(input bit sw_level, input int cycles);
    @(negedge i_clock);
    i_rst_n  = 1'b0;
    i_switch = sw_level;
    model_reset();
    repeat (cycles) @(negedge i_clock);
    i_rst_n = 1'b1;
  endtask

  int n;
  int count_before;
  int long_before;
  int rel_before;
  int exp_long;

  initial begin
    i_rst_n  = 1'b0;
    i_switch = 1'b1;
    model_reset();

    // Reset held with the switch high: outputs stay zero, then re-debounce from IDLE.
    repeat (20) @(negedge i_clock);
    check_all_zero("in_reset");
    i_rst_n = 1'b1;
    wait_press(n);
    check_output("press_latency", n - 1, 2 + DL);
    check_output("count_after_reset", o_press_count, 1);

    // Long hold: one pulse (three with auto-repeat over a 30-cycle level).
    @(negedge i_clock);
    long_before = long_seen;
    apply_stimulus(1'b1, 24);
    apply_stimulus(1'b0, 20);
`ifdef SWITCH_EVENT_REPEAT_EN
    exp_long = 3;
`else
    exp_long = 1;
`endif
    check_output("long_30", long_seen - long_before, exp_long);

    // Bounce shorter than the window: nothing accepted.
    count_before = o_press_count;
    apply_stimulus(1'b1, 2);
    apply_stimulus(1'b0, 2);
    apply_stimulus(1'b1, 2);
    apply_stimulus(1'b0, 20);
    check_output("bounce_count", o_press_count, count_before);
    check_output("bounce_level", o_filtered_switch, 0);

    // Short hold of 7 cycles: press and release but no long press.
    long_before = long_seen;
    rel_before  = rel_seen;
    apply_stimulus(1'b1, 7);
    apply_stimulus(1'b0, 20);
    check_output("short_long", long_seen - long_before, 0);
    check_output("short_release", rel_seen - rel_before, 1);

    // 35-cycle hold.
    long_before = long_seen;
    apply_stimulus(1'b1, 35);
    apply_stimulus(1'b0, 20);
`ifdef SWITCH_EVENT_REPEAT_EN
    exp_long = 3;
`else
    exp_long = 1;
`endif
    check_output("long_35", long_seen - long_before, exp_long);

    // Random bouncing and holds against the model.
    for (int k = 0; k < 300; k++) begin
      apply_stimulus(1'($urandom_range(1, 0)), int'($urandom_range(14, 1)));
    end
    apply_stimulus(1'b0, 20);

    // Counter wrap after 256 clean presses from a fresh reset.
    do_reset(1'b0, 3);
    for (int k = 0; k < 255; k++) begin
      apply_stimulus(1'b1, 6);
      apply_stimulus(1'b0, 6);
    end
    apply_stimulus(1'b0, 10);
    check_output("count_255", o_press_count, 255);
    apply_stimulus(1'b1, 6);
    apply_stimulus(1'b0, 16);
    check_output("count_wrap", o_press_count, 0);

    // Asynchronous reset five cycles into a hold.
    i_switch = 1'b1;
    wait_press(n);
    repeat (5) @(posedge i_clock);
    check_output("hold_level_before_reset", o_filtered_switch, 1);
    long_before = long_seen;
    rel_before  = rel_seen;
    #2;
    i_rst_n  = 1'b0;
    i_switch = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    repeat (3) @(negedge i_clock);
    i_rst_n = 1'b1;
    apply_stimulus(1'b0, 30);
    check_output("no_long_after_reset", long_seen - long_before, 0);
    check_output("no_release_after_reset", rel_seen - rel_before, 0);

    repeat (5) @(negedge i_clock);
    check_output("queue_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
